// File: rtl/alu16_muldiv_seq.sv
// Sequencer that borrows the shared 16-bit ALU for unsigned shift-add multiply
// and restoring divide, one granted ALU pass per bit.
module alu16_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmd,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        div0,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  output logic [1:0]  dbg_state
);
  localparam logic [2:0] OP_ADD = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // acc: hi (multiply) / partial remainder r (divide); sh: lo / q; opd: mcand / d
  logic [15:0] acc_q, acc_d, sh_q, sh_d, opd_q, opd_d;
  logic        busy_q, busy_d, done_q, done_d, div0_q, div0_d;
  logic [31:0] prod_q, prod_d;
  logic [15:0] quot_q, quot_d, rem_q, rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opd_q   <= opd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // ALU drive depends on registered state only, so it holds steady through a stall.
  always_comb begin
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_bnegate = 1'b0;
    alu_op      = OP_ADD;
    case (state_q)
      S_MUL: begin
        alu_req = 1'b1;
        alu_a   = acc_q;
        alu_b   = opd_q;
      end
      S_DIV: begin
        alu_req     = 1'b1;
        alu_a       = {acc_q[14:0], sh_q[15]};
        alu_b       = opd_q;
        alu_bnegate = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opd_d   = opd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (!cmd) begin
            acc_d   = '0;
            sh_d    = op_b;
            opd_d   = op_a;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else if (op_b != 16'd0) begin
            acc_d   = '0;
            sh_d    = op_a;
            opd_d   = op_b;
            busy_d  = 1'b1;
            state_d = S_DIV;
          end else begin
            quot_d  = 16'hFFFF;
            rem_d   = op_a;
            div0_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (alu_gnt) begin
          if (sh_q[0]) {acc_d, sh_d} = {alu_cout, alu_result, sh_q[15:1]};
          else         {acc_d, sh_d} = {1'b0, acc_q, sh_q[15:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            prod_d  = {acc_d, sh_d};
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (alu_gnt) begin
          // The bit shifted out of r (s[16]) means s already exceeds any 16-bit d.
          if (acc_q[15] || alu_cout) begin
            acc_d = alu_result;
            sh_d  = {sh_q[14:0], 1'b1};
          end else begin
            acc_d = {acc_q[14:0], sh_q[15]};
            sh_d  = {sh_q[14:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            quot_d  = sh_d;
            rem_d   = acc_d;
            div0_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign prod      = prod_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div0      = div0_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alu16_muldiv_seq.sv
// Bench for alu16_muldiv_seq: vector table, grant-stall and reset sequences,
// with a done-triggered scoreboard over the result outputs.
module tb_alu16_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cmd = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy, done, div0;
  logic [31:0] prod;
  logic [15:0] quot, rem;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  logic [15:0] alu_a, alu_b;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic [1:0]  dbg_state;
  logic [16:0] alu_sum;

  alu16_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .prod(prod), .quot(quot), .rem(rem), .div0(div0),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .dbg_state(dbg_state)
  );

  // Shared ALU stand-in: add, or A-B as A + ~B + 1 when BNegate is set.
  assign alu_sum    = {1'b0, alu_a} + {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {16'd0, alu_bnegate};
  assign alu_result = alu_sum[15:0];
  assign alu_cout   = alu_sum[16];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {prod, quot, rem, div0}
  logic [64:0] exp_q[$];
  logic [31:0] m_prod = '0;
  logic [15:0] m_quot = '0, m_rem = '0;
  logic        m_div0 = 1'b0;

  typedef struct packed {
    logic        c;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] e_prod;
    logic [15:0] e_quot;
    logic [15:0] e_rem;
    logic        e_div0;
    int          e_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("prod", prod, e[64:33]);
        check("quot", 32'(quot), 32'(e[32:17]));
        check("rem", 32'(rem), 32'(e[16:1]));
        check("div0", 32'(div0), 32'(e[0]));
      end
    end
  end

  task automatic run_op(input logic c, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] ep, input logic [15:0] eq, input logic [15:0] er,
                        input logic ed, input int exp_lat, input int stall_at, input int stall_len);
    int lat, busy_n, stall_left;
    logic req_seen;
    logic [15:0] sa, sb;
    logic sbn;
    if (!c) m_prod = ep;
    else begin m_quot = eq; m_rem = er; m_div0 = ed; end
    exp_q.push_back({m_prod, m_quot, m_rem, m_div0});
    @(negedge clk);
    start = 1'b1; cmd = c; op_a = a; op_b = b;
    @(posedge clk);
    #1 start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
    lat = 0; busy_n = 0; req_seen = 1'b0; stall_left = stall_len;
    sa = '0; sb = '0; sbn = 1'b0;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (alu_req) req_seen = 1'b1;
      if (stall_left > 0 && lat >= stall_at) begin
        if (lat == stall_at) begin
          sa = alu_a; sb = alu_b; sbn = alu_bnegate;
        end else begin
          check("stall_alu_a", 32'(alu_a), 32'(sa));
          check("stall_alu_b", 32'(alu_b), 32'(sb));
          check("stall_bneg", 32'(alu_bnegate), 32'(sbn));
          check("stall_req", 32'(alu_req), 32'd1);
        end
        alu_gnt = 1'b0;
        start = 1'($urandom_range(0, 1));
        cmd = 1'($urandom_range(0, 1));
        op_b = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom);
        stall_left--;
      end else begin
        alu_gnt = 1'b1;
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    alu_gnt = 1'b1;
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_n), 32'(exp_lat));
    check("req_seen", 32'(req_seen), 32'(!(c && b == 16'd0)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_prod"}, prod, 32'd0);
    check({tag, "_quot"}, 32'(quot), 32'd0);
    check({tag, "_rem"}, 32'(rem), 32'd0);
    check({tag, "_div0"}, 32'(div0), 32'd0);
    check({tag, "_req"}, 32'(alu_req), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_bneg"}, 32'(alu_bnegate), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rc;
    logic [15:0] ra, rb;
    int          sl;
    vecs[0] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060, 16'h0000, 16'h0000, 1'b0, 16};
    vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'h0000, 16'h0000, 1'b0, 16};
    vecs[2] = '{1'b0, 16'h0000, 16'hABCD, 32'h00000000, 16'h0000, 16'h0000, 1'b0, 16};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0003, 32'h0,        16'h5555, 16'h0000, 1'b0, 16};
    vecs[4] = '{1'b1, 16'h03E8, 16'h0007, 32'h0,        16'h008E, 16'h0006, 1'b0, 16};
    vecs[5] = '{1'b1, 16'h0005, 16'h8001, 32'h0,        16'h0000, 16'h0005, 1'b0, 16};
    vecs[6] = '{1'b1, 16'h1234, 16'h0000, 32'h0,        16'hFFFF, 16'h1234, 1'b1, 0};

    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].e_prod, vecs[i].e_quot,
             vecs[i].e_rem, vecs[i].e_div0, vecs[i].e_lat, 0, 0);

    // Five ungranted cycles mid-multiply with start noise while busy.
    run_op(1'b0, 16'h1234, 16'h5678, 32'h06260060, 16'h0, 16'h0, 1'b0, 21, 6, 5);

    for (int i = 0; i < 6; i++) begin
      rc = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      sl = (rc && rb == 16'd0) ? 0 : $urandom_range(0, 3);
      run_op(rc, ra, rb, 32'(ra) * 32'(rb),
             (rb == 16'd0) ? 16'hFFFF : ra / rb,
             (rb == 16'd0) ? ra : ra % rb,
             rc && (rb == 16'd0),
             (rc && rb == 16'd0) ? 0 : 16 + sl, $urandom_range(1, 14), sl);
    end

    // Reset in the middle of a divide: nothing survives.
    @(negedge clk);
    start = 1'b1; cmd = 1'b1; op_a = 16'h03E8; op_b = 16'h0007;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 check("busy_pre_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    m_prod = '0; m_quot = '0; m_rem = '0; m_div0 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16'h0, 16'h0, 1'b0, 16, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu16_muldiv_seq.md
# alu16_muldiv_seq

Multi-cycle controller that sequences the shared 16-bit ALU to perform unsigned 16x16 multiply (32-bit product) and unsigned 16/16 divide (quotient and remainder). Multiply uses shift-add and divide uses restoring division, one ALU pass per bit. The block drives the ALU operand and control inputs and consumes its Result and CarryOut. It requests the ALU through a req/gnt pair, so it can share the ALU with the main datapath, and it stalls while not granted.

## Interface
- OP_ADD, 3'b010, ALU Op code selecting add/subtract (subtract = OP_ADD with BNegate=1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; accepted only in IDLE
- cmd  in  1  0 = multiply, 1 = divide; sampled with start
- op_a  in  16  multiplicand / dividend; sampled with start
- op_b  in  16  multiplier / divisor; sampled with start
- busy  out  1  high from accept until the last iteration completes
- done  out  1  one-cycle pulse; results valid
- prod  out  32  multiply result, held until next accept
- quot  out  16  divide quotient, held until next accept
- rem  out  16  divide remainder, held until next accept
- div0  out  1  divisor was zero on last divide; held until next accept
- alu_req  out  1  ALU requested (high in MUL and DIV states)
- alu_gnt  in  1  ALU granted this cycle
- alu_a  out  16  ALU A operand
- alu_b  out  16  ALU B operand
- alu_bnegate  out  1  ALU BNegate
- alu_op  out  3  ALU Op (always OP_ADD)
- alu_result  in  16  ALU Result
- alu_cout  in  1  ALU CarryOut

## Operation
- States: IDLE, MUL, DIV, DONE. A 5-bit iteration counter tracks progress.
- IDLE: on start=1, latch op_a and op_b and clear the counter.
  - cmd=0: go to MUL.
  - cmd=1 and op_b!=0: go to DIV.
  - cmd=1 and op_b==0: go to DONE with quot=16'hFFFF, rem=op_a, div0=1.
- MUL registers: hi[15:0]=0, lo[15:0]=multiplier, mcand=op_a.
  - ALU drive: alu_a=hi, alu_b=mcand, alu_bnegate=0.
  - Granted cycle with lo[0]=1: {hi,lo} <= {alu_cout, alu_result, lo[15:1]}.
  - Granted cycle with lo[0]=0: {hi,lo} <= {1'b0, hi, lo[15:1]}.
  - After the 16th granted iteration: prod={hi,lo}, go to DONE.
- DIV registers: r[15:0]=0, q[15:0]=dividend, d=op_b. Each iteration forms the shifted partial remainder s={r,q[15]} (17 bits).
  - ALU drive: alu_a=s[15:0], alu_b=d, alu_bnegate=1 (A-B).
  - Accept when s[16]=1 or alu_cout=1: r<=alu_result, q<={q[14:0],1'b1}.
  - Otherwise: r<=s[15:0], q<={q[14:0],1'b0}.
  - After the 16th granted iteration: quot=q, rem=r, div0=0, go to DONE.
- Iterations advance only on cycles with alu_gnt=1. A cycle with alu_gnt=0 leaves all state unchanged; ALU drive and alu_req stay stable.
- DONE: done=1 for one cycle, then return to IDLE. start is ignored in DONE, MUL and DIV, with no queuing.
- In IDLE and DONE: alu_a=0, alu_b=0, alu_bnegate=0, alu_req=0. alu_op=OP_ADD at all times.
- Results update only at the transition into DONE. A multiply leaves quot/rem/div0 unchanged; a divide leaves prod unchanged.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0.
  - Output reset values: busy=0, done=0, prod=0, quot=0, rem=0, div0=0, alu_req=0, alu_a=0, alu_b=0, alu_bnegate=0.
  - Reset mid-operation aborts the operation; results are not retained.
- Let start be sampled at edge k, with alu_gnt held at 1.
  - busy rises after edge k.
  - Iterations occur at edges k+1..k+16.
  - busy falls and done=1 after edge k+16.
  - IDLE resumes after edge k+17; the next start is accepted no earlier than edge k+17.
- Each cycle with alu_gnt=0 during MUL/DIV adds one cycle of latency.
- Divide-by-zero: done=1 after edge k, busy stays 0, no ALU request.
- ALU is combinational; alu_result/alu_cout are used in the same cycle alu_a/alu_b are driven (single-cycle ALU path).
- busy, done and all result outputs are registered. alu_* outputs are decoded from registered state only.

## Test plan
- Multiply with gnt=1: start, cmd=0, 0x1234 x 0x5678 -> done 16 cycles after accept, prod=32'h06260060, busy high exactly 16 cycles.
- Multiply full scale: 0xFFFF x 0xFFFF -> prod=32'hFFFE0001 (exercises alu_cout into hi). 0x0000 x 0xABCD -> prod=0.
- Divide:
  - 0xFFFF / 0x0003 -> quot=0x5555, rem=0.
  - 0x03E8 / 0x0007 -> quot=0x008E, rem=0x0006.
  - 0x0005 / 0x8001 -> quot=0, rem=0x0005.
  - All three with div0=0.
- Divide by zero: 0x1234 / 0 -> done after 1 cycle, quot=0xFFFF, rem=0x1234, div0=1, alu_req never asserted.
- Grant stall: drop alu_gnt for 5 cycles mid-multiply, with random start pulses while busy -> done at 21 cycles, same prod, ALU drive stable during the stall, extra starts ignored.
- Reset mid-divide: assert rst_n=0 at iteration 8 -> all outputs 0 immediately. A new multiply after release completes normally.
